// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared widths and FSM state encoding for the block-copy DMA
package dma_pkg;

  localparam int DMA_AW = 8;
  localparam int DMA_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

endpackage

// File: rtl/mem_copy_dma_if.sv
// rtl/mem_copy_dma_if.sv - data-memory port shared by the DMA (master) and the memory (slave)
interface mem_copy_dma_if
  import dma_pkg::*;
#(
  parameter int AW = DMA_AW,
  parameter int DW = DMA_DW
);

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wr;
  logic [DW-1:0] mem_rdata;

  modport master (output mem_addr, output mem_wdata, output mem_wr, input mem_rdata);
  modport slave  (input mem_addr, input mem_wdata, input mem_wr, output mem_rdata);

endinterface

// File: rtl/dma_csum.sv
// rtl/dma_csum.sv - modulo-2^DW running sum of bytes read; used only with DMA_CHECKSUM_EN
module dma_csum
  import dma_pkg::*;
#(
  parameter int DW = DMA_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          acc_en,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] sum
);

  logic [DW-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (acc_en) begin
      sum_d = sum_q + data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule

// File: rtl/mem_copy_dma.sv
// rtl/mem_copy_dma.sv - byte-at-a-time block copy master on the data memory port
// Optional checksum output/accumulator enabled by DMA_CHECKSUM_EN.
module mem_copy_dma
  import dma_pkg::*;
#(
  parameter int AW = DMA_AW,
  parameter int DW = DMA_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [AW-1:0]        src,
  input  logic [AW-1:0]        dst,
  input  logic [AW-1:0]        len,
  mem_copy_dma_if.master       mem,
  output logic                 busy,
  output logic                 done
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [DW-1:0]        checksum
`endif
);

  dma_state_t    state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] i_q, i_d;
  logic [DW-1:0] buf_q, buf_d;
  logic [AW-1:0] i_inc;

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dst_d         = dst_q;
    len_d         = len_q;
    i_d           = i_q;
    buf_d         = buf_q;
    busy          = 1'b0;
    done          = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_wr    = 1'b0;
    i_inc         = i_q + AW'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src;
          dst_d   = dst;
          len_d   = len;
          i_d     = '0;
          state_d = (len == '0) ? DONE : READ;
        end
      end
      READ: begin
        busy         = 1'b1;
        mem.mem_addr = src_q + i_q;
        if (abort) begin
          state_d = IDLE;
        end else begin
          buf_d   = mem.mem_rdata;
          state_d = WRITE;
        end
      end
      WRITE: begin
        busy          = 1'b1;
        mem.mem_addr  = dst_q + i_q;
        mem.mem_wdata = buf_q;
        // Abort is the one combinational path to the port: an aborted cycle must not write.
        mem.mem_wr    = !abort;
        if (abort) begin
          state_d = IDLE;
        end else begin
          i_d     = i_inc;
          state_d = (i_inc == len_q) ? DONE : READ;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      i_q     <= i_d;
      buf_q   <= buf_d;
    end
  end

`ifdef DMA_CHECKSUM_EN
  logic csum_clr;
  logic csum_acc;

  assign csum_clr = (state_q == IDLE) && start;
  assign csum_acc = (state_q == READ) && !abort;

  dma_csum #(.DW(DW)) u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (csum_clr),
    .acc_en (csum_acc),
    .data   (mem.mem_rdata),
    .sum    (checksum)
  );
`endif

endmodule
